stack_mem_ctrl: RTL and testbench

//   Memory side of the CPU stack: the push/pop responder paired with the stack pointer.
//   On push it samples the shared 16-bit bus and writes that word into on-chip RAM.
//   On pop it reads the top word back and drives it onto the bus for one cycle.

---
 rtl/stack_mem_ctrl_pkg.sv | 12 +
 rtl/stack_ram.sv | 29 ++
 rtl/stack_mem_ctrl.sv | 119 +++++++++++
 tb/tb_stack_mem_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/stack_mem_ctrl_pkg.sv
// Shared definitions for the stack memory controller: data word width and FSM state encoding.
package stack_mem_ctrl_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRIVE = 2'd2
    } state_e;

endpackage

// File: rtl/stack_ram.sv
// Stack storage: DEPTH x WORD_W, synchronous write, registered read with one cycle of latency.
module stack_ram
    import stack_mem_ctrl_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              i_clock,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // NOTE: no reset on the array or read register; contents are only meaningful once written,
    // and a reset here would keep the array from mapping onto block RAM.
    always_ff @(posedge i_clock) begin
        if (i_we) begin
            mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= mem[i_addr];
        end
    end

endmodule

// File: rtl/stack_mem_ctrl.sv
// Memory side of the CPU stack: pushes bus words into RAM, pops the top word back onto the bus.
module stack_mem_ctrl
    import stack_mem_ctrl_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    inout  wire  [0:WORD_W-1] bus,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_clear,
    output logic              o_busy,
    output logic              o_valid,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              idle;
    logic              push_ok, push_ovf, pop_ok, pop_unf;
    logic              ram_re;
    logic [WORD_W-1:0] bus_in;
    logic [WORD_W-1:0] rd_data;

    assign bus_in = bus;

    // Requests are only decoded in IDLE; push has priority over a simultaneous pop.
    always_comb begin
        idle     = (state_q == ST_IDLE);
        push_ok  = idle && i_push && !o_full;
        push_ovf = idle && i_push && o_full;
        pop_ok   = idle && !i_push && i_pop && !o_empty;
        pop_unf  = idle && !i_push && i_pop && o_empty;
    end

    always_comb begin
        count_d = count_q;
        if (push_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok) begin
            count_d = count_q - 1'b1;
        end
        // A new error in the same cycle as a clear leaves the flag set.
        ovf_d = push_ovf ? 1'b1 : (i_clear ? 1'b0 : ovf_q);
        unf_d = pop_unf  ? 1'b1 : (i_clear ? 1'b0 : unf_q);
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of block ordering.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pop_ok) state_d = ST_READ;
            ST_READ:  state_d = ST_DRIVE;
            ST_DRIVE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy  = (state_q == ST_READ) || (state_q == ST_DRIVE);
        o_valid = (state_q == ST_DRIVE);
        ram_re  = (state_q == ST_READ);
    end

    // In READ the address is the already-decremented count, i.e. the top entry.
    stack_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clock (i_clock),
        .i_we    (push_ok),
        .i_re    (ram_re),
        .i_addr  (count_q[ADDR_W-1:0]),
        .i_wdata (bus_in),
        .o_rdata (rd_data)
    );

    assign bus = o_valid ? rd_data : 'z;

    assign o_count     = count_q;
    assign o_empty     = (count_q == '0);
    assign o_full      = (count_q == FULL_CNT);
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Directed bench for stack_mem_ctrl: push/pop ordering, full/empty boundaries, errors, abort.
module tb_stack_mem_ctrl;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic              clk;
    logic              rst_n;
    logic              push, pop, clear;
    logic              busy, valid, full, empty, ovf, unf;
    logic [ADDR_W:0]   count;
    logic              tb_drive;
    logic [15:0]       tb_data;
    wire  [0:15]       bus;
    logic [15:0]       bus_val;

    int checks = 0;
    int errors = 0;

    assign bus     = tb_drive ? tb_data : 'z;
    assign bus_val = bus;

    stack_mem_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .bus         (bus),
        .i_push      (push),
        .i_pop       (pop),
        .i_clear     (clear),
        .o_busy      (busy),
        .o_valid     (valid),
        .o_full      (full),
        .o_empty     (empty),
        .o_count     (count),
        .o_overflow  (ovf),
        .o_underflow (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] d);
        push     = 1'b1;
        tb_drive = 1'b1;
        tb_data  = d;
        tick();
        push     = 1'b0;
        tb_drive = 1'b0;
    endtask

    // Pop the top word: one request cycle, one READ cycle, one DRIVE cycle.
    task automatic pop_expect(input string tag, input logic [15:0] exp);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check({tag, "_busy_rd"}, 32'(busy), 32'd1);
        check({tag, "_valid_rd"}, 32'(valid), 32'd0);
        tick();
        check({tag, "_busy_dr"}, 32'(busy), 32'd1);
        check({tag, "_valid_dr"}, 32'(valid), 32'd1);
        check({tag, "_bus"}, 32'(bus_val), 32'(exp));
        tick();
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_valid_idle"}, 32'(valid), 32'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; push = 1'b0; pop = 1'b0; clear = 1'b0;
        tb_drive = 1'b0; tb_data = '0;

        // 1. Reset state, single push then pop
        apply_reset();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_unf", 32'(unf), 32'd0);
        push_word(16'hA5A5);
        check("t1_count", 32'(count), 32'd1);
        check("t1_empty", 32'(empty), 32'd0);
        pop_expect("t1_pop", 16'hA5A5);
        check("t1_count_after", 32'(count), 32'd0);
        check("t1_empty_after", 32'(empty), 32'd1);

        // 2. LIFO ordering over back-to-back pushes
        push_word(16'h0001);
        push_word(16'h0002);
        push_word(16'h0003);
        check("t2_count", 32'(count), 32'd3);
        pop_expect("t2_pop3", 16'h0003);
        pop_expect("t2_pop2", 16'h0002);
        pop_expect("t2_pop1", 16'h0001);
        check("t2_empty", 32'(empty), 32'd1);

        // 3. Fill to DEPTH, overflow, clear
        for (int i = 0; i < DEPTH; i++) begin
            push_word(16'(i));
            if (i == DEPTH - 2) begin
                check("t3_not_full", 32'(full), 32'd0);
                check("t3_count_m1", 32'(count), 32'(DEPTH - 1));
            end
        end
        check("t3_full", 32'(full), 32'd1);
        check("t3_count_full", 32'(count), 32'(DEPTH));
        push_word(16'hFFFF);
        check("t3_ovf", 32'(ovf), 32'd1);
        check("t3_count_ovf", 32'(count), 32'(DEPTH));
        pop_expect("t3_top", 16'h00FF);
        check("t3_full_after", 32'(full), 32'd0);
        check("t3_ovf_held", 32'(ovf), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t3_ovf_clr", 32'(ovf), 32'd0);

        // 4. Underflow, clear vs new error, simultaneous push+pop
        apply_reset();
        check("t4_rst_count", 32'(count), 32'd0);
        pop = 1'b1;
        tick();
        check("t4_unf", 32'(unf), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_valid", 32'(valid), 32'd0);
        check("t4_count", 32'(count), 32'd0);
        clear = 1'b1;
        tick();
        check("t4_unf_wins", 32'(unf), 32'd1);
        pop = 1'b0;
        tick();
        clear = 1'b0;
        check("t4_unf_clr", 32'(unf), 32'd0);
        pop = 1'b1;
        push_word(16'h1234);
        pop = 1'b0;
        check("t4_both_count", 32'(count), 32'd1);
        check("t4_both_busy", 32'(busy), 32'd0);
        check("t4_both_unf", 32'(unf), 32'd0);
        check("t4_both_ovf", 32'(ovf), 32'd0);
        pop_expect("t4_pop", 16'h1234);

        // 5. Requests during READ ignored, reset aborts DRIVE
        push_word(16'h5555);
        push_word(16'h6666);
        pop = 1'b1;
        tick();
        check("t5_read_count", 32'(count), 32'd1);
        push = 1'b1;
        tb_drive = 1'b1;
        tb_data = 16'h7777;
        tick();
        push = 1'b0;
        pop = 1'b0;
        tb_drive = 1'b0;
        #1;
        check("t5_ign_count", 32'(count), 32'd1);
        check("t5_ign_unf", 32'(unf), 32'd0);
        check("t5_drive_valid", 32'(valid), 32'd1);
        check("t5_drive_bus", 32'(bus_val), 32'h6666);
        rst_n = 1'b0;
        tick();
        check("t5_abort_valid", 32'(valid), 32'd0);
        check("t5_abort_busy", 32'(busy), 32'd0);
        check("t5_abort_count", 32'(count), 32'd0);
        check("t5_abort_empty", 32'(empty), 32'd1);
        rst_n = 1'b1;
        tick();
        check("t5_post_valid", 32'(valid), 32'd0);
        check("t5_post_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
